// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the stack-machine control sequencer.
//
// Holds the opcode map, ALU function codes, the select encodings used on the
// datapath multiplexers, the sequencer state enum and the instruction class
// that the sequencer remembers between DECODE and the end of an instruction.
//
// Optional feature macro: CPU_SEQ_CALL_EN (CALL/RET opcodes, see cpu_decode).
package cpu_pkg;

  // Opcode map (bits [15:10] of the command register)
  localparam int OP_NOP   = 'h00;
  localparam int OP_PUSHI = 'h01;
  localparam int OP_POP   = 'h02;
  localparam int OP_ADD   = 'h03;
  localparam int OP_SUB   = 'h04;
  localparam int OP_AND   = 'h05;
  localparam int OP_OR    = 'h06;
  localparam int OP_XOR   = 'h07;
  localparam int OP_JMP   = 'h08;
  localparam int OP_CALL  = 'h09;
  localparam int OP_RET   = 'h0A;
  localparam int OP_HALT  = 'h3F;

  // ALU function codes
  localparam int ALU_PASS_A = 0;
  localparam int ALU_ADD    = 1;
  localparam int ALU_SUB    = 2;
  localparam int ALU_AND    = 3;
  localparam int ALU_OR     = 4;
  localparam int ALU_XOR    = 5;

  // SR / PC next-value select
  localparam logic [1:0] SEL_ALU    = 2'd0;
  localparam logic [1:0] SEL_INCDEC = 2'd1;
  localparam logic [1:0] SEL_START  = 2'd2;

  // Memory address select
  localparam logic [1:0] ADDR_SR_OUT = 2'd0;
  localparam logic [1:0] ADDR_SR_ID  = 2'd1;
  localparam logic [1:0] ADDR_PC_OUT = 2'd2;
  localparam logic [1:0] ADDR_PC_ID  = 2'd3;

  // Memory write-data select
  localparam logic [1:0] DATA_SR_OUT  = 2'd0;
  localparam logic [1:0] DATA_PC_ID   = 2'd1;
  localparam logic [1:0] DATA_ALU_RES = 2'd2;
  localparam logic [1:0] DATA_CMD     = 2'd3;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_POPA_INC,
    S_POPA_RD,
    S_POPB_INC,
    S_POPB_RD,
    S_PUSH_IMM,
    S_PUSH_ALU,
    S_CALL_PUSH,
    S_JUMP,
    S_HALT,
    S_ERROR
  } state_t;

  // What to do after the first operand has been popped into R1
  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_POP,
    CLS_BIN,
    CLS_JMP,
    CLS_CALL
  } op_class_t;

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode -- purely combinational opcode decoder.
//
// Ports:
//   opcode      in   OPCODE_W    current command opcode
//   first_state out  state_t     state entered right after DECODE
//   op_class    out  op_class_t  continuation after the first pop
//   alu_func    out  ALU_FUNC_W  ALU function used by PUSH_ALU
//   legal       out  1           opcode is recognised (not routed to ERROR)
//
// Optional feature macro: CPU_SEQ_CALL_EN -- when defined, 0x09 decodes as
// CALL and 0x0A as RET (behaves like JMP); otherwise both are illegal.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int ALU_FUNC_W = 3
) (
  input  logic [OPCODE_W-1:0]   opcode,
  output state_t                first_state,
  output op_class_t             op_class,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  legal
);

  always_comb begin
    first_state = S_ERROR;
    op_class    = CLS_NONE;
    alu_func    = ALU_FUNC_W'(ALU_PASS_A);
    legal       = 1'b0;
    case (opcode)
      OPCODE_W'(OP_NOP): begin
        legal       = 1'b1;
        first_state = S_FETCH;
      end
      OPCODE_W'(OP_PUSHI): begin
        legal       = 1'b1;
        first_state = S_PUSH_IMM;
      end
      OPCODE_W'(OP_POP): begin
        legal       = 1'b1;
        first_state = S_POPA_INC;
        op_class    = CLS_POP;
      end
      OPCODE_W'(OP_ADD): begin
        legal       = 1'b1;
        first_state = S_POPA_INC;
        op_class    = CLS_BIN;
        alu_func    = ALU_FUNC_W'(ALU_ADD);
      end
      OPCODE_W'(OP_SUB): begin
        legal       = 1'b1;
        first_state = S_POPA_INC;
        op_class    = CLS_BIN;
        alu_func    = ALU_FUNC_W'(ALU_SUB);
      end
      OPCODE_W'(OP_AND): begin
        legal       = 1'b1;
        first_state = S_POPA_INC;
        op_class    = CLS_BIN;
        alu_func    = ALU_FUNC_W'(ALU_AND);
      end
      OPCODE_W'(OP_OR): begin
        legal       = 1'b1;
        first_state = S_POPA_INC;
        op_class    = CLS_BIN;
        alu_func    = ALU_FUNC_W'(ALU_OR);
      end
      OPCODE_W'(OP_XOR): begin
        legal       = 1'b1;
        first_state = S_POPA_INC;
        op_class    = CLS_BIN;
        alu_func    = ALU_FUNC_W'(ALU_XOR);
      end
      OPCODE_W'(OP_JMP): begin
        legal       = 1'b1;
        first_state = S_POPA_INC;
        op_class    = CLS_JMP;
      end
`ifdef CPU_SEQ_CALL_EN
      OPCODE_W'(OP_CALL): begin
        legal       = 1'b1;
        first_state = S_POPA_INC;
        op_class    = CLS_CALL;
      end
      // RET pops the return address and jumps to it, exactly like JMP
      OPCODE_W'(OP_RET): begin
        legal       = 1'b1;
        first_state = S_POPA_INC;
        op_class    = CLS_JMP;
      end
`endif
      OPCODE_W'(OP_HALT): begin
        legal       = 1'b1;
        first_state = S_HALT;
      end
      default: begin
        legal       = 1'b0;
        first_state = S_ERROR;
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- Moore control FSM for a small stack-machine CPU.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   opcode        in  OPCODE_W command register bits [15:10]
//   cmd_w r1_w r2_w sr_w pc_w  out register write enables
//   sr_inc pc_inc              out incdec direction (1 = +1, 0 = -1)
//   sr_sel pc_sel        [1:0] out next-value select (ALU/incdec/start)
//   addr_sel             [1:0] out memory address select
//   data_sel             [1:0] out memory write data select
//   alu_func    [ALU_FUNC_W-1:0] out ALU function
//   write_memory error halted  out
//
// Optional feature macro: CPU_SEQ_CALL_EN enables CALL (0x09) and RET (0x0A).
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int ALU_FUNC_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPCODE_W-1:0]   opcode,
  output logic                  cmd_w,
  output logic                  r1_w,
  output logic                  r2_w,
  output logic                  sr_w,
  output logic                  pc_w,
  output logic                  sr_inc,
  output logic                  pc_inc,
  output logic [1:0]            sr_sel,
  output logic [1:0]            pc_sel,
  output logic [1:0]            addr_sel,
  output logic [1:0]            data_sel,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  write_memory,
  output logic                  error,
  output logic                  halted
);

  state_t                state_q, state_d;
  logic                  direct_q, direct_d;
  op_class_t             class_q;
  logic [ALU_FUNC_W-1:0] alu_q;

  state_t                dec_first;
  op_class_t             dec_class;
  logic [ALU_FUNC_W-1:0] dec_alu;
  logic                  dec_legal;

  cpu_decode #(
    .OPCODE_W   (OPCODE_W),
    .ALU_FUNC_W (ALU_FUNC_W)
  ) u_decode (
    .opcode      (opcode),
    .first_state (dec_first),
    .op_class    (dec_class),
    .alu_func    (dec_alu),
    .legal       (dec_legal)
  );

  // State and direct-fetch flag. The flag means "PC already holds the address
  // of the next command", so FETCH reads PC_out instead of pre-incrementing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      direct_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      direct_q <= direct_d;
    end
  end

  // The instruction class and ALU function are captured only in DECODE so a
  // later change on opcode cannot disturb an instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      class_q <= CLS_NONE;
      alu_q   <= '0;
    end else if (state_q == S_DECODE && dec_legal) begin
      class_q <= dec_class;
      alu_q   <= dec_alu;
    end
  end

  always_comb begin
    state_d      = state_q;
    direct_d     = direct_q;
    cmd_w        = 1'b0;
    r1_w         = 1'b0;
    r2_w         = 1'b0;
    sr_w         = 1'b0;
    pc_w         = 1'b0;
    sr_inc       = 1'b0;
    pc_inc       = 1'b0;
    sr_sel       = SEL_ALU;
    pc_sel       = SEL_ALU;
    addr_sel     = ADDR_SR_OUT;
    data_sel     = DATA_SR_OUT;
    alu_func     = ALU_FUNC_W'(ALU_PASS_A);
    write_memory = 1'b0;
    error        = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_INIT: begin
        sr_w     = 1'b1;
        pc_w     = 1'b1;
        sr_sel   = SEL_START;
        pc_sel   = SEL_START;
        direct_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        cmd_w = 1'b1;
        if (direct_q) begin
          addr_sel = ADDR_PC_OUT;
        end else begin
          addr_sel = ADDR_PC_ID;
          pc_w     = 1'b1;
          pc_sel   = SEL_INCDEC;
          pc_inc   = 1'b1;
        end
        direct_d = 1'b0;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        state_d = dec_first;
      end
      // The stack grows downwards, so a pop increments SR first
      S_POPA_INC, S_POPB_INC: begin
        sr_w    = 1'b1;
        sr_sel  = SEL_INCDEC;
        sr_inc  = 1'b1;
        state_d = (state_q == S_POPA_INC) ? S_POPA_RD : S_POPB_RD;
      end
      S_POPA_RD: begin
        addr_sel = ADDR_SR_OUT;
        r1_w     = 1'b1;
        case (class_q)
          CLS_BIN:  state_d = S_POPB_INC;
          CLS_JMP:  state_d = S_JUMP;
          CLS_CALL: state_d = S_CALL_PUSH;
          default:  state_d = S_FETCH;
        endcase
      end
      S_POPB_RD: begin
        addr_sel = ADDR_SR_OUT;
        r2_w     = 1'b1;
        state_d  = S_PUSH_ALU;
      end
      S_PUSH_IMM, S_PUSH_ALU: begin
        addr_sel     = ADDR_SR_OUT;
        write_memory = 1'b1;
        sr_w         = 1'b1;
        sr_sel       = SEL_INCDEC;
        sr_inc       = 1'b0;
        if (state_q == S_PUSH_ALU) begin
          data_sel = DATA_ALU_RES;
          alu_func = alu_q;
        end else begin
          data_sel = DATA_CMD;
        end
        state_d = S_FETCH;
      end
      // Pushes PC_out + 1 (the incdec output) as the return address
      S_CALL_PUSH: begin
        addr_sel     = ADDR_SR_OUT;
        data_sel     = DATA_PC_ID;
        pc_inc       = 1'b1;
        write_memory = 1'b1;
        sr_w         = 1'b1;
        sr_sel       = SEL_INCDEC;
        sr_inc       = 1'b0;
        state_d      = S_JUMP;
      end
      // R1 passes through the ALU into PC; the next fetch reads PC directly
      S_JUMP: begin
        alu_func = ALU_FUNC_W'(ALU_PASS_A);
        pc_w     = 1'b1;
        pc_sel   = SEL_ALU;
        direct_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer -- self-checking bench for cpu_sequencer.
//
// Keeps a queue of expected per-cycle output vectors built from the
// instruction-level sequence of each opcode; every cycle the DUT outputs are
// compared with the queue head. Directed literal checks pin key cycles.
// Honours CPU_SEQ_CALL_EN the same way as the design.
module tb_cpu_sequencer;

  typedef struct packed {
    logic       cmd_w;
    logic       r1_w;
    logic       r2_w;
    logic       sr_w;
    logic       pc_w;
    logic       sr_inc;
    logic       pc_inc;
    logic [1:0] sr_sel;
    logic [1:0] pc_sel;
    logic [1:0] addr_sel;
    logic [1:0] data_sel;
    logic [2:0] alu_func;
    logic       write_memory;
    logic       error;
    logic       halted;
  } out_t;

  typedef struct {
    string name;
    out_t  o;
    bit    is_decode;
    bit    sticky;
  } exp_t;

`ifdef CPU_SEQ_CALL_EN
  localparam bit CallEn = 1'b1;
`else
  localparam bit CallEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       cmd_w, r1_w, r2_w, sr_w, pc_w, sr_inc, pc_inc;
  logic [1:0] sr_sel, pc_sel, addr_sel, data_sel;
  logic [2:0] alu_func;
  logic       write_memory, error, halted;
  out_t       dut_out;

  exp_t model_q[$];
  int   tests    = 0;
  int   failures = 0;

  cpu_sequencer #(
    .OPCODE_W   (6),
    .ALU_FUNC_W (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .cmd_w        (cmd_w),
    .r1_w         (r1_w),
    .r2_w         (r2_w),
    .sr_w         (sr_w),
    .pc_w         (pc_w),
    .sr_inc       (sr_inc),
    .pc_inc       (pc_inc),
    .sr_sel       (sr_sel),
    .pc_sel       (pc_sel),
    .addr_sel     (addr_sel),
    .data_sel     (data_sel),
    .alu_func     (alu_func),
    .write_memory (write_memory),
    .error        (error),
    .halted       (halted)
  );

  assign dut_out = {cmd_w, r1_w, r2_w, sr_w, pc_w, sr_inc, pc_inc, sr_sel,
                    pc_sel, addr_sel, data_sel, alu_func, write_memory, error,
                    halted};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector for each kind of cycle, straight from the
  // description of what each step of an instruction must drive.
  function automatic out_t oInit();
    out_t o = '0;
    o.sr_w = 1'b1; o.pc_w = 1'b1; o.sr_sel = 2'd2; o.pc_sel = 2'd2;
    return o;
  endfunction

  function automatic out_t oFetch(bit direct);
    out_t o = '0;
    o.cmd_w = 1'b1;
    if (direct) o.addr_sel = 2'd2;
    else begin
      o.addr_sel = 2'd3; o.pc_w = 1'b1; o.pc_sel = 2'd1; o.pc_inc = 1'b1;
    end
    return o;
  endfunction

  function automatic out_t oPopInc();
    out_t o = '0;
    o.sr_w = 1'b1; o.sr_sel = 2'd1; o.sr_inc = 1'b1;
    return o;
  endfunction

  function automatic out_t oPopRd(bit second);
    out_t o = '0;
    if (second) o.r2_w = 1'b1; else o.r1_w = 1'b1;
    return o;
  endfunction

  function automatic out_t oPush(logic [1:0] ds, logic [2:0] fn);
    out_t o = '0;
    o.data_sel = ds; o.alu_func = fn; o.write_memory = 1'b1;
    o.sr_w = 1'b1; o.sr_sel = 2'd1;
    return o;
  endfunction

  function automatic out_t oCallPush();
    out_t o = '0;
    o.data_sel = 2'd1; o.pc_inc = 1'b1; o.write_memory = 1'b1;
    o.sr_w = 1'b1; o.sr_sel = 2'd1;
    return o;
  endfunction

  function automatic out_t oJump();
    out_t o = '0;
    o.pc_w = 1'b1;
    return o;
  endfunction

  function automatic void pushExp(string name, out_t o, bit dec, bit sticky);
    exp_t e;
    e.name = name; e.o = o; e.is_decode = dec; e.sticky = sticky;
    model_q.push_back(e);
  endfunction

  // After reset the machine always runs INIT, a direct fetch, then DECODE
  function automatic void modelReset();
    model_q.delete();
    pushExp("init", oInit(), 1'b0, 1'b0);
    pushExp("fetch_direct", oFetch(1'b1), 1'b0, 1'b0);
    pushExp("decode", out_t'(0), 1'b1, 1'b0);
  endfunction

  // Expand one decoded opcode into the cycles that follow DECODE
  function automatic void expandOp(logic [5:0] op);
    int v = int'(op);
    bit direct = 1'b0;
    out_t o = '0;
    if (v == 1) begin
      pushExp("push_imm", oPush(2'd3, 3'd0), 1'b0, 1'b0);
    end else if (v == 2) begin
      pushExp("pop_inc", oPopInc(), 1'b0, 1'b0);
      pushExp("pop_rd_a", oPopRd(1'b0), 1'b0, 1'b0);
    end else if (v >= 3 && v <= 7) begin
      pushExp("popa_inc", oPopInc(), 1'b0, 1'b0);
      pushExp("popa_rd", oPopRd(1'b0), 1'b0, 1'b0);
      pushExp("popb_inc", oPopInc(), 1'b0, 1'b0);
      pushExp("popb_rd", oPopRd(1'b1), 1'b0, 1'b0);
      pushExp("push_alu", oPush(2'd2, 3'(v - 2)), 1'b0, 1'b0);
    end else if (v == 8 || (CallEn && v == 10)) begin
      pushExp("jmp_pop_inc", oPopInc(), 1'b0, 1'b0);
      pushExp("jmp_pop_rd", oPopRd(1'b0), 1'b0, 1'b0);
      pushExp("jump", oJump(), 1'b0, 1'b0);
      direct = 1'b1;
    end else if (CallEn && v == 9) begin
      pushExp("call_pop_inc", oPopInc(), 1'b0, 1'b0);
      pushExp("call_pop_rd", oPopRd(1'b0), 1'b0, 1'b0);
      pushExp("call_push", oCallPush(), 1'b0, 1'b0);
      pushExp("call_jump", oJump(), 1'b0, 1'b0);
      direct = 1'b1;
    end else if (v == 63) begin
      o.halted = 1'b1;
      pushExp("halt", o, 1'b0, 1'b1);
      return;
    end else if (v != 0) begin
      o.error = 1'b1;
      pushExp("error", o, 1'b0, 1'b1);
      return;
    end
    pushExp(direct ? "fetch_direct" : "fetch", oFetch(direct), 1'b0, 1'b0);
    pushExp("decode", out_t'(0), 1'b1, 1'b0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive inputs for the next rising edge and advance the model accordingly
  task automatic applyStimulus(input logic [5:0] op, input logic rst,
                               input bit was_decode);
    opcode = op;
    rst_n  = rst;
    if (!rst) modelReset();
    else if (was_decode) expandOp(op);
  endtask

  // One cycle: compare at the falling edge, then drive the next inputs
  task automatic step(input logic [5:0] op, input logic rst);
    exp_t e;
    @(negedge clk);
    if (model_q.size() == 0) begin
      $display("[TB] FAIL model_empty: got 0 entries, expected at least 1");
      $fatal(1, "[TB] model queue empty");
    end
    e = model_q[0];
    checkOutput(e.name, 32'(dut_out), 32'(e.o));
    if (!e.sticky) void'(model_q.pop_front());
    applyStimulus(op, rst, e.is_decode);
  endtask

  // Two-cycle reset; on return the DUT sits in INIT
  task automatic doReset();
    step(6'($urandom_range(0, 63)), 1'b0);
    step(6'($urandom_range(0, 63)), 1'b1);
  endtask

  // Directed scenarios with literal checks, then a long randomized run
  initial begin
    logic [5:0] op;
    logic       rst;
    int         r;
    int         stuck;
    applyStimulus(6'h00, 1'b0, 1'b0);

    // Reset release: INIT then a direct fetch
    doReset();
    checkOutput("init_writes", 32'({sr_w, pc_w, sr_sel, pc_sel}), 32'(6'b11_10_10));
    checkOutput("init_others", 32'({cmd_w, write_memory, error, halted}), 32'(0));
    step(6'h00, 1'b1);
    checkOutput("first_fetch", 32'({cmd_w, pc_w, addr_sel}), 32'(4'b1_0_10));

    // ADD, with opcode wiggling after DECODE
    step(6'h03, 1'b1);
    step(6'h3F, 1'b1);
    step(6'h15, 1'b1);
    step(6'h00, 1'b1);
    step(6'h3F, 1'b1);
    step(6'h01, 1'b1);
    checkOutput("push_alu", 32'({alu_func, data_sel, write_memory, sr_w}), 32'(7'b001_10_1_1));
    step(6'h00, 1'b1);
    checkOutput("fetch_after_add", 32'({cmd_w, addr_sel, pc_inc}), 32'(4'b1_11_1));

    // JMP
    step(6'h08, 1'b1);
    step(6'h00, 1'b1);
    step(6'h00, 1'b1);
    step(6'h00, 1'b1);
    checkOutput("jump_cycle", 32'({pc_w, pc_sel}), 32'(3'b1_00));
    step(6'h00, 1'b1);
    checkOutput("fetch_after_jmp", 32'({cmd_w, pc_w, addr_sel}), 32'(4'b1_0_10));

    // Opcode 0x09: CALL when enabled, otherwise illegal
    step(6'h09, 1'b1);
    step(6'h00, 1'b1);
`ifdef CPU_SEQ_CALL_EN
    step(6'h00, 1'b1);
    step(6'h00, 1'b1);
    checkOutput("call_push", 32'({data_sel, write_memory, pc_inc}), 32'(4'b01_1_1));
`else
    checkOutput("call_disabled", 32'(error), 32'(1));
`endif

    // Illegal opcode: sticky error with all writes low, cleared by reset
    doReset();
    step(6'h00, 1'b1);
    step(6'h15, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(6'($urandom_range(0, 63)), 1'b1);
      checkOutput("illegal_sticky",
                  32'({error, cmd_w, r1_w, r2_w, sr_w, pc_w, write_memory}),
                  32'(7'b1_000000));
    end
    doReset();
    checkOutput("error_cleared", 32'(error), 32'(0));

    // Reset during POPB_RD of SUB: INIT next, no memory write
    step(6'h00, 1'b1);
    step(6'h04, 1'b1);
    step(6'h00, 1'b1);
    step(6'h00, 1'b1);
    step(6'h00, 1'b1);
    step(6'h00, 1'b0);
    step(6'h00, 1'b1);
    checkOutput("reset_mid_instr", 32'({write_memory, sr_sel, pc_sel}), 32'(5'b0_10_10));

    // Randomized opcodes and occasional resets
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 80) op = 6'($urandom_range(0, 10));
      else if (r < 86) op = 6'h3F;
      else op = 6'($urandom_range(0, 63));
      if (model_q.size() != 0 && model_q[0].sticky) stuck++;
      else stuck = 0;
      rst = 1'b1;
      if (stuck > 6 || $urandom_range(0, 79) == 0) rst = 1'b0;
      step(op, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode field width.
REQ-002 Parameter ALU_FUNC_W, default 3, ALU function select width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 opcode  input  OPCODE_W  bits [15:10] of the command register.
REQ-006 cmd_w, r1_w, r2_w, sr_w, pc_w  output  1 each  register write enables.
REQ-007 sr_inc, pc_inc  output  1 each  incdec direction: 1 = +1, 0 = -1.
REQ-008 sr_sel, pc_sel  output  2 each  next-value select: 0 = ALU, 1 = incdec, 2 = start constant.
REQ-009 addr_sel  output  2  address select: 0 = SR_out, 1 = SR_id, 2 = PC_out, 3 = PC_id.
REQ-010 data_sel  output  2  write data select: 0 = SR_out, 1 = PC_id, 2 = ALU_res, 3 = cmd.
REQ-011 alu_func  output  ALU_FUNC_W  encoding: 0 = PASS_A, 1 = ADD, 2 = SUB, 3 = AND, 4 = OR, 5 = XOR.
REQ-012 write_memory, error, halted  output  1 each.

Function
REQ-013 The block SHALL be a Moore FSM with states INIT, FETCH, DECODE, POPA_INC, POPA_RD, POPB_INC, POPB_RD, PUSH_IMM, PUSH_ALU, CALL_PUSH, JUMP, HALT, ERROR.
REQ-014 Any write enable or write_memory not named for a state SHALL be 0 in that state.
REQ-015 INIT SHALL assert sr_w and pc_w with sr_sel = pc_sel = 2, set the direct-fetch flag, then go to FETCH.
REQ-016 FETCH with direct flag = 0: addr_sel = 3, cmd_w = 1, pc_w = 1, pc_sel = 1, pc_inc = 1.
REQ-017 FETCH with direct flag = 1: addr_sel = 2, cmd_w = 1, pc_w = 0; the flag then clears.
REQ-018 DECODE opcode map: 0x00 NOP goes to FETCH.
REQ-019 DECODE opcode map: 0x01 PUSHI goes to PUSH_IMM.
REQ-020 DECODE opcode map: 0x02 POP goes to POPA_INC, then POPA_RD, then FETCH.
REQ-021 DECODE opcode map: 0x03-0x07 ADD/SUB/AND/OR/XOR go to POPA_INC.
REQ-022 DECODE opcode map: 0x08 JMP goes to POPA_INC.
REQ-023 DECODE opcode map: 0x3F goes to HALT; any other opcode goes to ERROR.
REQ-024 POPx_INC: sr_w = 1, sr_sel = 1, sr_inc = 1.
REQ-025 POPA_RD: addr_sel = 0, r1_w = 1.
REQ-026 POPB_RD: addr_sel = 0, r2_w = 1.
REQ-027 Binary ops SHALL run POPA_INC, POPA_RD, POPB_INC, POPB_RD, PUSH_ALU; result = R1 op R2, where R1 is the former top of stack.
REQ-028 PUSH_IMM: addr_sel = 0, data_sel = 3, write_memory = 1, sr_w = 1, sr_sel = 1, sr_inc = 0.
REQ-029 PUSH_ALU SHALL drive the same signals as PUSH_IMM, with data_sel = 2 and alu_func taken from the latched opcode.
REQ-030 JUMP: alu_func = PASS_A, pc_w = 1, pc_sel = 0, set direct flag, go to FETCH.
REQ-031 Cycle counts including FETCH: NOP 2, PUSHI 3, POP 4, binary op 7, JMP 5.
REQ-032 HALT and ERROR SHALL be absorbing states with all writes deasserted.
REQ-033 halted SHALL be 1 in HALT; error SHALL be 1 in ERROR; both are sticky until reset.
REQ-034 ALU operation SHALL be latched at DECODE; a change on opcode after DECODE SHALL have no effect.

Reset
REQ-035 rst_n = 0 at a clock edge SHALL force INIT, clear the direct flag, and clear error and halted, from any state including mid-instruction.
REQ-036 While in INIT, every output other than those named in REQ-015 SHALL be 0.

Configuration
REQ-037 Macro CPU_SEQ_CALL_EN defined: opcode 0x09 CALL SHALL run POPA_INC, POPA_RD, CALL_PUSH, JUMP.
REQ-038 CALL_PUSH: addr_sel = 0, data_sel = 1, pc_inc = 1, write_memory = 1, SR decrement (return address = PC_out + 1).
REQ-039 Macro CPU_SEQ_CALL_EN defined: opcode 0x0A RET SHALL run as JMP.
REQ-040 Macro CPU_SEQ_CALL_EN undefined: opcodes 0x09 and 0x0A SHALL go to ERROR.

Structure
REQ-041 Package cpu_pkg SHALL hold opcode constants, ALU function codes, select encodings, and the state enum.
REQ-042 Sub-module cpu_decode (opcode to first state, ALU function, legality) SHALL be combinational; the FSM stays in cpu_sequencer.

Verification
REQ-043 Reset release -> INIT asserts sr_w and pc_w with sel 2; next cycle FETCH with addr_sel = 2, pc_w = 0.
REQ-044 Opcode 0x03 -> seven-cycle sequence; PUSH_ALU drives alu_func = 1, data_sel = 2, write_memory = 1.
REQ-045 Opcode 0x08 -> JUMP cycle has pc_sel = 0; the following FETCH drives addr_sel = 2.
REQ-046 Opcode 0x15 -> error = 1 from the next cycle, write enables stay 0 for 10 cycles; rst_n = 0 clears error.
REQ-047 Opcode 0x09, built with and without CPU_SEQ_CALL_EN -> CALL_PUSH with data_sel = 1 vs. ERROR.
REQ-048 rst_n = 0 during POPB_RD -> next state INIT, no write_memory pulse.
